// File: rtl/ddrphy_dll_update_ctrl.sv
// DDR PHY DLL update responder: arbitrates reset-controller, training and periodic
// requests, then runs a freeze -> update -> settle sequence and acknowledges the requester.
module ddrphy_dll_update_ctrl #(
    parameter int unsigned FREEZE_CYC = 4,
    parameter int unsigned UPDATE_CYC = 8,
    parameter int unsigned HOLD_CYC   = 4,
    parameter int unsigned PERIOD_CYC = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dll_lock,
    input  logic       dll_update_req_rst_ctrl,
    output logic       dll_update_ack_rst_ctrl,
    input  logic       dll_update_req_train,
    output logic       dll_update_ack_train,
    input  logic       periodic_en,
    output logic       dll_freeze,
    output logic       dll_update,
    output logic       busy,
    output logic       lock_lost,
    output logic [7:0] update_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FREEZE,
        S_UPDATE,
        S_SETTLE,
        S_ACK
    } state_t;

    typedef enum logic [1:0] {
        G_NONE,
        G_RST,
        G_TRAIN,
        G_PER
    } grant_t;

    state_t      state_q, state_d;
    grant_t      grant_q, grant_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [23:0] timer_q, timer_d;
    logic        pend_q, pend_d;

    logic [1:0]  req_rst_sync_q, req_rst_sync_d;
    logic [1:0]  req_train_sync_q, req_train_sync_d;
    logic [1:0]  lock_sync_q, lock_sync_d;

    logic        freeze_q, freeze_d;
    logic        update_q, update_d;
    logic        ack_rst_q, ack_rst_d;
    logic        ack_train_q, ack_train_d;
    logic        busy_q, busy_d;
    logic        lock_lost_q, lock_lost_d;
    logic [7:0]  update_cnt_q, update_cnt_d;

    logic        req_rst_s, req_train_s, dll_lock_s;
    logic        done;

    assign req_rst_s   = req_rst_sync_q[1];
    assign req_train_s = req_train_sync_q[1];
    assign dll_lock_s  = lock_sync_q[1];

    always_comb begin
        req_rst_sync_d   = {req_rst_sync_q[0], dll_update_req_rst_ctrl};
        req_train_sync_d = {req_train_sync_q[0], dll_update_req_train};
        lock_sync_d      = {lock_sync_q[0], dll_lock};
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        cnt_d   = cnt_q + 8'd1;
        done    = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (dll_lock_s) begin
                    if (req_rst_s) begin
                        grant_d = G_RST;
                        state_d = S_FREEZE;
                    end else if (req_train_s) begin
                        grant_d = G_TRAIN;
                        state_d = S_FREEZE;
                    end else if (pend_q) begin
                        grant_d = G_PER;
                        state_d = S_FREEZE;
                    end
                end
            end
            S_FREEZE: begin
                if (cnt_q == 8'(FREEZE_CYC - 1)) begin
                    state_d = S_UPDATE;
                    cnt_d   = '0;
                end
            end
            S_UPDATE: begin
                if (cnt_q == 8'(UPDATE_CYC - 1)) begin
                    state_d = S_SETTLE;
                    cnt_d   = '0;
                end
            end
            S_SETTLE: begin
                if (cnt_q == 8'(HOLD_CYC - 1)) begin
                    state_d = S_ACK;
                    cnt_d   = '0;
                end
            end
            S_ACK: begin
                cnt_d = '0;
                // Hardware requesters hold ACK until their req drops; periodic grants leave after one cycle.
                case (grant_q)
                    G_RST:   done = !req_rst_s;
                    G_TRAIN: done = !req_train_s;
                    default: done = 1'b1;
                endcase
                if (done) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        freeze_d     = (state_q == S_FREEZE) || (state_q == S_UPDATE);
        update_d     = (state_q == S_UPDATE);
        ack_rst_d    = (state_q == S_ACK) && (grant_q == G_RST);
        ack_train_d  = (state_q == S_ACK) && (grant_q == G_TRAIN);
        busy_d       = (state_q != S_IDLE);
        lock_lost_d  = lock_lost_q ||
                       (!dll_lock_s && ((state_q == S_FREEZE) || (state_q == S_UPDATE) ||
                                        (state_q == S_SETTLE)));
        update_cnt_d = done ? update_cnt_q + 8'd1 : update_cnt_q;
    end

    always_comb begin
        timer_d = timer_q;
        pend_d  = pend_q;
        if (done) begin
            timer_d = 24'(PERIOD_CYC);
            pend_d  = 1'b0;
        end else if (periodic_en && (PERIOD_CYC != 0)) begin
            if (timer_q == '0) begin
                pend_d = 1'b1;
            end else begin
                timer_d = timer_q - 24'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= S_IDLE;
            grant_q          <= G_NONE;
            cnt_q            <= '0;
            timer_q          <= 24'(PERIOD_CYC);
            pend_q           <= 1'b0;
            req_rst_sync_q   <= '0;
            req_train_sync_q <= '0;
            lock_sync_q      <= '0;
            freeze_q         <= 1'b0;
            update_q         <= 1'b0;
            ack_rst_q        <= 1'b0;
            ack_train_q      <= 1'b0;
            busy_q           <= 1'b0;
            lock_lost_q      <= 1'b0;
            update_cnt_q     <= '0;
        end else begin
            state_q          <= state_d;
            grant_q          <= grant_d;
            cnt_q            <= cnt_d;
            timer_q          <= timer_d;
            pend_q           <= pend_d;
            req_rst_sync_q   <= req_rst_sync_d;
            req_train_sync_q <= req_train_sync_d;
            lock_sync_q      <= lock_sync_d;
            freeze_q         <= freeze_d;
            update_q         <= update_d;
            ack_rst_q        <= ack_rst_d;
            ack_train_q      <= ack_train_d;
            busy_q           <= busy_d;
            lock_lost_q      <= lock_lost_d;
            update_cnt_q     <= update_cnt_d;
        end
    end

    assign dll_freeze              = freeze_q;
    assign dll_update              = update_q;
    assign dll_update_ack_rst_ctrl = ack_rst_q;
    assign dll_update_ack_train    = ack_train_q;
    assign busy                    = busy_q;
    assign lock_lost               = lock_lost_q;
    assign update_cnt              = update_cnt_q;

endmodule

// File: tb/tb_ddrphy_dll_update_ctrl.sv
// Directed bench for ddrphy_dll_update_ctrl: edge-accurate latency, arbitration,
// lock handling, periodic self-update and mid-sequence reset.
module tb_ddrphy_dll_update_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       dll_lock;
    logic       req_rst;
    logic       ack_rst;
    logic       req_train;
    logic       ack_train;
    logic       periodic_en;
    logic       dll_freeze;
    logic       dll_update;
    logic       busy;
    logic       lock_lost;
    logic [7:0] update_cnt;

    int checks = 0;
    int errors = 0;

    ddrphy_dll_update_ctrl #(
        .FREEZE_CYC(4),
        .UPDATE_CYC(8),
        .HOLD_CYC  (4),
        .PERIOD_CYC(64)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .dll_lock               (dll_lock),
        .dll_update_req_rst_ctrl(req_rst),
        .dll_update_ack_rst_ctrl(ack_rst),
        .dll_update_req_train   (req_train),
        .dll_update_ack_train   (ack_train),
        .periodic_en            (periodic_en),
        .dll_freeze             (dll_freeze),
        .dll_update             (dll_update),
        .busy                   (busy),
        .lock_lost              (lock_lost),
        .update_cnt             (update_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag, input logic [7:0] cnt_exp);
        check({tag, " freeze"}, 32'(dll_freeze), 0);
        check({tag, " update"}, 32'(dll_update), 0);
        check({tag, " ack_rst"}, 32'(ack_rst), 0);
        check({tag, " ack_train"}, 32'(ack_train), 0);
        check({tag, " busy"}, 32'(busy), 0);
        check({tag, " lock_lost"}, 32'(lock_lost), 0);
        check({tag, " update_cnt"}, 32'(update_cnt), 32'(cnt_exp));
    endtask

    initial begin
        int first_a, first_b, last_f, bad, both, any_ack, inc1, inc2;
        logic [7:0] prev_cnt;

        rst = 1'b1; dll_lock = 1'b1; req_rst = 1'b0; req_train = 1'b0; periodic_en = 1'b0;
        repeat (3) tick();
        check_all_zero("reset", 8'd0);
        rst = 1'b0;
        repeat (5) tick();
        check_all_zero("idle", 8'd0);

        // Single rst_ctrl request; iteration e is sampled just after edge e.
        req_rst = 1'b1;
        for (int e = 0; e <= 32; e++) begin
            tick();
            check($sformatf("t1 freeze e%0d", e), 32'(dll_freeze), 32'(e >= 3 && e <= 14));
            check($sformatf("t1 update e%0d", e), 32'(dll_update), 32'(e >= 7 && e <= 14));
            check($sformatf("t1 ack_rst e%0d", e), 32'(ack_rst), 32'(e >= 19 && e <= 27));
            check($sformatf("t1 ack_train e%0d", e), 32'(ack_train), 0);
            check($sformatf("t1 busy e%0d", e), 32'(busy), 32'(e >= 3 && e <= 27));
            if (e == 24) req_rst = 1'b0;
        end
        check("t1 update_cnt", 32'(update_cnt), 1);

        // Simultaneous requests: rst_ctrl first, train on first IDLE after.
        first_a = -1; first_b = -1; both = 0;
        req_rst = 1'b1; req_train = 1'b1;
        for (int e = 0; e <= 60; e++) begin
            tick();
            if (ack_rst && ack_train) both++;
            if (ack_rst && first_a < 0) first_a = e;
            if (ack_train && first_b < 0) first_b = e;
            if (ack_rst) req_rst = 1'b0;
            if (ack_train) req_train = 1'b0;
        end
        check("t2 first ack_rst edge", 32'(first_a), 19);
        check("t2 first ack_train edge", 32'(first_b), 40);
        check("t2 acks overlap", 32'(both), 0);
        check("t2 update_cnt", 32'(update_cnt), 3);

        // No grant without lock; sequence starts once lock returns.
        dll_lock = 1'b0;
        repeat (4) tick();
        req_rst = 1'b1;
        bad = 0;
        repeat (100) begin
            tick();
            if (dll_freeze || busy) bad++;
        end
        check("t3 activity without lock", 32'(bad), 0);
        dll_lock = 1'b1;
        first_a = -1; first_b = -1;
        for (int e = 0; e <= 30; e++) begin
            tick();
            if (dll_freeze && first_a < 0) first_a = e;
            if (ack_rst && first_b < 0) first_b = e;
            if (ack_rst) req_rst = 1'b0;
        end
        check("t3 freeze rise edge", 32'(first_a), 3);
        check("t3 ack rise edge", 32'(first_b), 19);
        check("t3 lock_lost", 32'(lock_lost), 0);
        check("t3 update_cnt", 32'(update_cnt), 4);

        // Lock glitch during UPDATE: timing unchanged, sticky lock_lost.
        first_a = -1; last_f = -1;
        req_rst = 1'b1;
        for (int e = 0; e <= 30; e++) begin
            tick();
            if (dll_freeze) last_f = e;
            if (ack_rst && first_a < 0) first_a = e;
            if (ack_rst) req_rst = 1'b0;
            if (e == 7) dll_lock = 1'b0;
            if (e == 9) dll_lock = 1'b1;
        end
        check("t4 last freeze edge", 32'(last_f), 14);
        check("t4 ack rise edge", 32'(first_a), 19);
        check("t4 lock_lost", 32'(lock_lost), 1);
        check("t4 update_cnt", 32'(update_cnt), 5);
        repeat (10) tick();
        check("t4 lock_lost sticky", 32'(lock_lost), 1);

        // Periodic self-update with PERIOD_CYC = 64.
        first_a = -1; any_ack = 0; inc1 = -1; inc2 = -1;
        prev_cnt = update_cnt;
        periodic_en = 1'b1;
        for (int e = 1; e <= 170; e++) begin
            tick();
            if (dll_freeze && first_a < 0) first_a = e;
            if (ack_rst || ack_train) any_ack++;
            if (update_cnt != prev_cnt) begin
                if (inc1 < 0) inc1 = e;
                else if (inc2 < 0) inc2 = e;
            end
            prev_cnt = update_cnt;
        end
        periodic_en = 1'b0;
        check("t5 first freeze edge", 32'(first_a), 67);
        check("t5 first completion edge", 32'(inc1), 83);
        check("t5 second completion edge", 32'(inc2), 166);
        check("t5 acks seen", 32'(any_ack), 0);
        check("t5 update_cnt", 32'(update_cnt), 7);

        // Reset while in SETTLE, then a fresh request.
        req_rst = 1'b1;
        for (int e = 0; e <= 15; e++) tick();
        check("t6 busy before reset", 32'(busy), 1);
        rst = 1'b1; req_rst = 1'b0;
        tick();
        check_all_zero("t6 after reset", 8'd0);
        rst = 1'b0;
        repeat (5) tick();
        check("t6 idle busy", 32'(busy), 0);
        first_a = -1;
        req_rst = 1'b1;
        for (int e = 0; e <= 30; e++) begin
            tick();
            if (ack_rst && first_a < 0) first_a = e;
            if (ack_rst) req_rst = 1'b0;
        end
        check("t6 fresh ack edge", 32'(first_a), 19);
        check("t6 update_cnt", 32'(update_cnt), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
